// File: rtl/lb_pkg.sv
// Shared widths and record types for the load-balancer dataplane blocks.
package lb_pkg;

  localparam int IPV4_W  = 32;
  localparam int MAC_W   = 48;
  localparam int LB_ID_W = 8;

  typedef struct packed {
    logic [LB_ID_W-1:0] id;
    logic [IPV4_W-1:0]  ip;
  } lb_desc_t;

  typedef struct packed {
    logic [LB_ID_W-1:0] id;
    logic [MAC_W-1:0]   mac;
  } lb_resolved_t;

endpackage

// File: rtl/lb_sync_fifo.sv
// Single-clock FIFO with show-ahead read; push while full is honoured when a pop frees the slot.
module lb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/next_hop_resolver.sv
// Turns forwarding descriptors into ARP cache queries and pairs in-order responses
// with their packet ids, emitting resolved {id, mac} or drop events.
module next_hop_resolver
  import lb_pkg::*;
#(
  parameter int ID_W  = LB_ID_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [ID_W-1:0]   desc_id_i,
  input  logic [IPV4_W-1:0] desc_ip_i,
  output logic              query_req_valid_o,
  input  logic              query_req_ready_i,
  output logic [IPV4_W-1:0] query_ip_o,
  input  logic              query_resp_valid_i,
  output logic              query_resp_ready_o,
  input  logic [MAC_W-1:0]  query_mac_i,
  input  logic              query_err_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ID_W-1:0]   out_id_o,
  output logic [MAC_W-1:0]  out_mac_o,
  output logic              drop_o,
  output logic [ID_W-1:0]   drop_id_o,
  output logic [CNT_W-1:0]  miss_count_o,
  output logic              orphan_err_o
);

  logic              req_full;
  logic [ID_W-1:0]   req_id;
  logic [IPV4_W-1:0] req_ip;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   fifo_head;
  logic              desc_fire;
  logic              query_fire;
  logic              resp_fire;
  logic              resp_pop;
  logic              resp_orphan;

  // A query may only leave when its tag has somewhere to live.
  assign query_req_valid_o  = req_full && !fifo_full;
  assign query_fire         = query_req_valid_o && query_req_ready_i;
  assign query_ip_o         = req_ip;
  assign desc_ready_o       = !req_full || query_fire;
  assign desc_fire          = desc_valid_i && desc_ready_o;

  // Errors never need the output register, so they are accepted even under backpressure.
  assign query_resp_ready_o = query_err_i || fifo_empty || !out_valid_o || out_ready_i;
  assign resp_fire          = query_resp_valid_i && query_resp_ready_o;
  assign resp_pop           = resp_fire && !fifo_empty;
  assign resp_orphan        = resp_fire && fifo_empty;

  lb_sync_fifo #(
    .WIDTH (ID_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (query_fire),
    .push_data (req_id),
    .pop       (resp_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_full <= 1'b0;
      req_id   <= '0;
      req_ip   <= '0;
    end else if (desc_fire) begin
      req_full <= 1'b1;
      req_id   <= desc_id_i;
      req_ip   <= desc_ip_i;
    end else if (query_fire) begin
      req_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o  <= 1'b0;
      out_id_o     <= '0;
      out_mac_o    <= '0;
      drop_o       <= 1'b0;
      drop_id_o    <= '0;
      miss_count_o <= '0;
      orphan_err_o <= 1'b0;
    end else begin
      drop_o <= resp_pop && query_err_i;
      if (resp_pop && query_err_i) drop_id_o <= fifo_head;

      if (resp_pop && !query_err_i) begin
        out_valid_o <= 1'b1;
        out_id_o    <= fifo_head;
        out_mac_o   <= query_mac_i;
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
        out_id_o    <= '0;
        out_mac_o   <= '0;
      end

      // Counter sticks at all-ones rather than wrapping.
      if (resp_pop && query_err_i && !(&miss_count_o)) miss_count_o <= miss_count_o + 1'b1;
      if (resp_orphan) orphan_err_o <= 1'b1;
    end
  end

endmodule
